// File: rtl/maquina_venda_pkg.sv
// Shared definitions for the vending controller: product codes, coin values and FSM states.
package maquina_venda_pkg;

    localparam logic [3:0] COD_REFRI    = 4'b1111;
    localparam logic [3:0] COD_SAL      = 4'b1110;
    localparam logic [3:0] COD_SUCO     = 4'b1100;
    localparam logic [3:0] COD_INVALIDO = 4'b0000;

    localparam logic [4:0] VAL_A = 5'd1;
    localparam logic [4:0] VAL_B = 5'd2;
    localparam logic [4:0] VAL_C = 5'd1;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        CREDITO   = 2'd1,
        LIBERANDO = 2'd2,
        TROCO     = 2'd3
    } estado_t;

    // Simultaneous coin pulses are summed; the total never exceeds 4.
    function automatic logic [4:0] valor_moedas(input logic a, input logic b, input logic c);
        return (a ? VAL_A : 5'd0) + (b ? VAL_B : 5'd0) + (c ? VAL_C : 5'd0);
    endfunction

endpackage

// File: rtl/maquina_venda_ctrl_tabela_preco.sv
// Combinational product-code to price decode; shared with the display block.
module tabela_preco
    import maquina_venda_pkg::*;
#(
    parameter int PRECO_REFRI = 5,
    parameter int PRECO_SAL   = 3,
    parameter int PRECO_SUCO  = 4
) (
    input  logic [3:0] produto,
    output logic [3:0] preco,
    output logic       valido
);

    // Price lookup; unknown codes report zero price and invalid.
    always_comb begin
        preco  = 4'd0;
        valido = 1'b0;
        case (produto)
            COD_REFRI: begin
                preco  = 4'(PRECO_REFRI);
                valido = 1'b1;
            end
            COD_SAL: begin
                preco  = 4'(PRECO_SAL);
                valido = 1'b1;
            end
            COD_SUCO: begin
                preco  = 4'(PRECO_SUCO);
                valido = 1'b1;
            end
            COD_INVALIDO: begin
                preco  = 4'd0;
                valido = 1'b0;
            end
            default: begin
                preco  = 4'd0;
                valido = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/maquina_venda_ctrl.sv
// Vending controller: accumulates credit, validates purchases, times the dispense strobe
// and returns change. All outputs are registered.
module maquina_venda_ctrl
    import maquina_venda_pkg::*;
#(
    parameter int PRECO_REFRI = 5,
    parameter int PRECO_SAL   = 3,
    parameter int PRECO_SUCO  = 4,
    parameter int SALDO_MAX   = 15,
    parameter int CICLOS_LIB  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       moeda_a,
    input  logic       moeda_b,
    input  logic       moeda_c,
    input  logic [3:0] produto,
    input  logic       confirmar,
    input  logic       cancelar,
    output logic [3:0] saldo,
    output logic       liberar,
    output logic [3:0] prod_lib,
    output logic [3:0] troco,
    output logic       troco_valido,
    output logic       rejeita,
    output logic       erro
);

    localparam logic [3:0] CNT_INI = 4'(CICLOS_LIB - 1);
    localparam logic [4:0] LIMITE  = 5'(SALDO_MAX);

    estado_t    estado_r;
    logic [3:0] cnt_r;
    logic [3:0] preco_s;
    logic       preco_valido_s;
    logic [4:0] valor_s;
    logic [4:0] soma_s;
    logic       moeda_s;

    tabela_preco #(
        .PRECO_REFRI (PRECO_REFRI),
        .PRECO_SAL   (PRECO_SAL),
        .PRECO_SUCO  (PRECO_SUCO)
    ) u_tabela_preco (
        .produto (produto),
        .preco   (preco_s),
        .valido  (preco_valido_s)
    );

    // Coin value of this cycle and the credit it would produce if accepted.
    always_comb begin
        valor_s = valor_moedas(moeda_a, moeda_b, moeda_c);
        soma_s  = {1'b0, saldo} + valor_s;
        moeda_s = (valor_s != 5'd0);
    end

    // Control FSM with registered outputs; strobes default low every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_r     <= OCIOSO;
            cnt_r        <= 4'd0;
            saldo        <= 4'd0;
            liberar      <= 1'b0;
            prod_lib     <= 4'd0;
            troco        <= 4'd0;
            troco_valido <= 1'b0;
            rejeita      <= 1'b0;
            erro         <= 1'b0;
        end else begin
            troco_valido <= 1'b0;
            rejeita      <= 1'b0;
            erro         <= 1'b0;
            case (estado_r)
                OCIOSO, CREDITO: begin
                    if (cancelar && (saldo != 4'd0)) begin
                        troco        <= saldo;
                        troco_valido <= 1'b1;
                        saldo        <= 4'd0;
                        rejeita      <= moeda_s;
                        estado_r     <= TROCO;
                    end else if (confirmar && preco_valido_s && (saldo >= preco_s)) begin
                        prod_lib <= produto;
                        saldo    <= saldo - preco_s;
                        liberar  <= 1'b1;
                        cnt_r    <= CNT_INI;
                        rejeita  <= moeda_s;
                        estado_r <= LIBERANDO;
                    end else begin
                        // A refused request does not block coins arriving with it.
                        erro <= confirmar;
                        if (moeda_s) begin
                            if (soma_s <= LIMITE) begin
                                saldo    <= soma_s[3:0];
                                estado_r <= CREDITO;
                            end else begin
                                rejeita <= 1'b1;
                            end
                        end
                    end
                end
                LIBERANDO: begin
                    rejeita <= moeda_s;
                    if (cnt_r == 4'd0) begin
                        liberar <= 1'b0;
                        if (saldo != 4'd0) begin
                            troco        <= saldo;
                            troco_valido <= 1'b1;
                            saldo        <= 4'd0;
                            estado_r     <= TROCO;
                        end else begin
                            estado_r <= OCIOSO;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                TROCO: begin
                    rejeita  <= moeda_s;
                    saldo    <= 4'd0;
                    estado_r <= OCIOSO;
                end
                default: begin
                    estado_r <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maquina_venda_ctrl.sv
// Scoreboard bench for maquina_venda_ctrl: directed scenarios then random traffic
// against a cycle-level behavioural model.
module tb_maquina_venda_ctrl;

    localparam int CICLOS = 4;
    localparam int MAXS   = 15;

    logic       clk = 1'b0;
    logic       reset, moeda_a, moeda_b, moeda_c, confirmar, cancelar;
    logic [3:0] produto;
    logic [3:0] saldo, prod_lib, troco;
    logic       liberar, troco_valido, rejeita, erro;

    typedef struct packed {
        logic [3:0] saldo;
        logic       liberar;
        logic [3:0] prod_lib;
        logic [3:0] troco;
        logic       troco_valido;
        logic       rejeita;
        logic       erro;
    } saida_t;

    saida_t fila[$];
    string  nomes[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    int m_saldo = 0, m_lib = 0, m_prod = 0, m_troco = 0, m_in_troco = 0;

    maquina_venda_ctrl #(
        .PRECO_REFRI (5),
        .PRECO_SAL   (3),
        .PRECO_SUCO  (4),
        .SALDO_MAX   (MAXS),
        .CICLOS_LIB  (CICLOS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .moeda_a      (moeda_a),
        .moeda_b      (moeda_b),
        .moeda_c      (moeda_c),
        .produto      (produto),
        .confirmar    (confirmar),
        .cancelar     (cancelar),
        .saldo        (saldo),
        .liberar      (liberar),
        .prod_lib     (prod_lib),
        .troco        (troco),
        .troco_valido (troco_valido),
        .rejeita      (rejeita),
        .erro         (erro)
    );

    always #5 clk = ~clk;

    function automatic int preco_de(input logic [3:0] p);
        case (p)
            4'b1111: return 5;
            4'b1110: return 3;
            4'b1100: return 4;
            default: return -1;
        endcase
    endfunction

    // Drive one cycle of inputs, advance the model and queue what the DUT must show after the edge.
    task automatic ciclo(input logic rst, input logic a, input logic b, input logic c,
                         input logic [3:0] prod, input logic conf, input logic canc,
                         input string nm);
        int v, p;
        bit rej, err, tv;
        saida_t e;
        @(negedge clk);
        reset = rst; moeda_a = a; moeda_b = b; moeda_c = c;
        produto = prod; confirmar = conf; cancelar = canc;
        v = int'(a) + 2 * int'(b) + int'(c);
        rej = 0; err = 0; tv = 0;
        if (rst) begin
            m_saldo = 0; m_lib = 0; m_prod = 0; m_troco = 0; m_in_troco = 0;
        end else if (m_in_troco != 0) begin
            m_in_troco = 0;
            rej = (v > 0);
        end else if (m_lib > 0) begin
            rej = (v > 0);
            m_lib--;
            if (m_lib == 0 && m_saldo > 0) begin
                m_troco = m_saldo; m_saldo = 0; tv = 1; m_in_troco = 1;
            end
        end else begin
            p = preco_de(prod);
            if (canc && m_saldo > 0) begin
                m_troco = m_saldo; m_saldo = 0; tv = 1; m_in_troco = 1;
                rej = (v > 0);
            end else if (conf && p > 0 && m_saldo >= p) begin
                m_prod = int'(prod); m_saldo -= p; m_lib = CICLOS;
                rej = (v > 0);
            end else begin
                err = conf;
                if (v > 0) begin
                    if (m_saldo + v <= MAXS) m_saldo += v;
                    else rej = 1;
                end
            end
        end
        e.saldo        = 4'(m_saldo);
        e.liberar      = (m_lib > 0);
        e.prod_lib     = 4'(m_prod);
        e.troco        = 4'(m_troco);
        e.troco_valido = tv;
        e.rejeita      = rej;
        e.erro         = err;
        fila.push_back(e);
        nomes.push_back(nm);
    endtask

    task automatic ocioso(input int n, input string nm);
        for (int i = 0; i < n; i++) ciclo(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, nm);
    endtask

    task automatic espera_borda();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Monitor: after every active edge compare the DUT outputs with the oldest queued expectation.
    initial begin
        saida_t g, e;
        string  nm;
        forever begin
            @(posedge clk);
            #1;
            if (fila.size() > 0) begin
                e  = fila.pop_front();
                nm = nomes.pop_front();
                g  = '{saldo, liberar, prod_lib, troco, troco_valido, rejeita, erro};
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got saldo=%0d lib=%b prod=%h troco=%0d tv=%b rej=%b err=%b, expected saldo=%0d lib=%b prod=%h troco=%0d tv=%b rej=%b err=%b",
                             nm, $time, g.saldo, g.liberar, g.prod_lib, g.troco, g.troco_valido, g.rejeita, g.erro,
                             e.saldo, e.liberar, e.prod_lib, e.troco, e.troco_valido, e.rejeita, e.erro);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a, b, c, cf, cn, rs;
        logic [3:0] pr;
        reset = 1'b1; moeda_a = 1'b0; moeda_b = 1'b0; moeda_c = 1'b0;
        produto = 4'h0; confirmar = 1'b0; cancelar = 1'b0;

        ciclo(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, "reset");
        ciclo(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, "reset");
        espera_borda();
        chk("reset_saldo", int'(saldo), 0);

        // Exact credit for refri: dispense, no change.
        ciclo(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "moeda_b1");
        ciclo(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "moeda_b2");
        ciclo(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, "moeda_a");
        espera_borda();
        chk("saldo_5", int'(saldo), 5);
        ciclo(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, "conf_refri");
        espera_borda();
        chk("lib_alto", int'(liberar), 1);
        chk("prod_lib_F", int'(prod_lib), 15);
        ocioso(4, "lib_refri");
        espera_borda();
        chk("lib_fim", int'(liberar), 0);
        chk("sem_troco", int'(troco_valido), 0);

        // Salgadinho with change of 1.
        ciclo(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "moeda_b");
        ciclo(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "moeda_b");
        ciclo(1'b0, 1'b0, 1'b0, 1'b0, 4'hE, 1'b1, 1'b0, "conf_sal");
        ocioso(4, "lib_sal");
        espera_borda();
        chk("troco_valido_sal", int'(troco_valido), 1);
        chk("troco_1", int'(troco), 1);
        ocioso(1, "pos_troco");

        // Insufficient credit and invalid code.
        ciclo(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "moeda_b");
        ciclo(1'b0, 1'b0, 1'b0, 1'b0, 4'hC, 1'b1, 1'b0, "conf_suco_pobre");
        espera_borda();
        chk("erro_suco", int'(erro), 1);
        chk("saldo_2", int'(saldo), 2);
        ciclo(1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 1'b1, 1'b0, "conf_invalido");
        espera_borda();
        chk("erro_invalido", int'(erro), 1);
        ciclo(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, "cancel");
        ocioso(2, "pos_cancel");

        // Credit ceiling.
        for (int i = 0; i < 7; i++) ciclo(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "enche");
        ciclo(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "estouro_ab");
        espera_borda();
        chk("rej_ab", int'(rejeita), 1);
        chk("saldo_14", int'(saldo), 14);
        ciclo(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, "chega_15");
        espera_borda();
        chk("saldo_15", int'(saldo), 15);
        ciclo(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, "estouro_c");
        espera_borda();
        chk("rej_c", int'(rejeita), 1);
        ciclo(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, "cancel15");
        ocioso(2, "pos_cancel15");

        // Cancel with a coin in the same cycle.
        ciclo(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "moeda_3");
        ciclo(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, "cancel_moeda");
        espera_borda();
        chk("troco_3", int'(troco), 3);
        chk("rej_cancel", int'(rejeita), 1);
        chk("saldo_0", int'(saldo), 0);
        ocioso(1, "pos_cancel3");

        // Coin during dispense.
        ciclo(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "moeda_b");
        ciclo(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "moeda_b");
        ciclo(1'b0, 1'b0, 1'b0, 1'b0, 4'hE, 1'b1, 1'b0, "conf_sal2");
        ciclo(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, "moeda_lib");
        espera_borda();
        chk("rej_lib", int'(rejeita), 1);
        chk("saldo_lib", int'(saldo), 1);
        ocioso(6, "fim_sal2");

        // Reset in the second cycle of liberar.
        for (int i = 0; i < 3; i++) ciclo(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "moeda_b");
        ciclo(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, "moeda_a");
        ciclo(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, "conf_refri2");
        ocioso(1, "lib_ciclo2");
        ciclo(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, "reset_lib");
        espera_borda();
        chk("reset_lib_liberar", int'(liberar), 0);
        chk("reset_lib_saldo", int'(saldo), 0);
        ocioso(6, "pos_reset_lib");

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(0, 199) == 0);
            a  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 3) == 0);
            c  = ($urandom_range(0, 3) == 0);
            cf = ($urandom_range(0, 7) == 0);
            cn = ($urandom_range(0, 15) == 0) && (m_saldo > 0);
            case ($urandom_range(0, 4))
                0: pr = 4'hF;
                1: pr = 4'hE;
                2: pr = 4'hC;
                3: pr = 4'h0;
                default: pr = 4'($urandom_range(0, 15));
            endcase
            ciclo(rs, a, b, c, pr, cf, cn, "aleatorio");
        end

        ocioso(3, "dreno");
        espera_borda();
        chk("fila_vazia", fila.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
